// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the fetch PC, issues one word request at a
// time to instruction memory over a valid/ready handshake, and presents the
// returned words (RD/PCF/PC_plus4F) to the fetch/decode pipeline register with
// an enable strobe (en_fd). Handles hazard stalls, execute-stage redirects,
// discarding of stale in-flight responses, and buffering of returned words
// while decode is stalled.
//
// Configuration macro:
//   FETCH_OUTBUF_EN  defined   -> output buffer DEPTH = 2 (fetch runs one word
//                                 ahead while stalled)
//                    undefined -> DEPTH = 1
//
// Parameters:
//   RESET_PC         fetch address after reset
//
// Ports:
//   clk              clock, all state updates on rising edge
//   rst              synchronous reset, active-high
//   stallF           hazard stall; 1 = decode must not capture this cycle
//   redirect_valid   single-cycle PC redirect from execute
//   redirect_pc      redirect target (bits [1:0] ignored)
//   imem_req_valid   memory request valid
//   imem_req_ready   memory accepts request this cycle
//   imem_addr        memory request word address
//   imem_rsp_valid   memory response valid
//   imem_rdata       memory response instruction word
//   RD               instruction presented to fetch/decode register
//   PCF              PC of RD
//   PC_plus4F        PCF + 4
//   en_fd            fetch/decode register enable; 1 = head entry consumed
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] RD,
    output logic [31:0] PCF,
    output logic [31:0] PC_plus4F,
    output logic        en_fd
);

`ifdef FETCH_OUTBUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        S_REQ,   // free to issue the next request
        S_WAIT,  // request outstanding, response will be kept
        S_DROP   // request outstanding, response is stale and discarded
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;        // next address to request
    logic [31:0] r_req_pc;    // address of the outstanding request

    // Output buffer, head at index 0.
    logic [31:0] r_buf_instr [DEPTH];
    logic [31:0] r_buf_pc    [DEPTH];
    logic [1:0]  r_count;

    logic [31:0] w_buf_instr_next [DEPTH];
    logic [31:0] w_buf_pc_next    [DEPTH];
    logic [1:0]  w_count_pop;
    logic [1:0]  w_count_next;

    logic [31:0] r_rd;
    logic [31:0] r_pcf;
    logic [31:0] r_pc_plus4;

    logic        w_req_valid;
    logic        w_accept;
    logic        w_push;
    logic [2:0]  w_free;

    // Consumption: head exists, decode not stalled, and no redirect flush.
    assign en_fd = ~rst & (r_count != 2'd0) & ~stallF & ~redirect_valid;

    // Credit counts the slot freed by a pop in this same cycle, so a request
    // can be issued while the last entry is being consumed.
    assign w_free = 3'(DEPTH) - {1'b0, r_count} + {2'b00, en_fd};

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_req_valid  = 1'b0;
        w_push       = 1'b0;
        unique case (r_state)
            S_REQ: begin
                w_req_valid = ~rst & ~redirect_valid & (w_free != 3'd0);
                if (w_req_valid && imem_req_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    // A response coinciding with a redirect is already stale.
                    w_push       = ~redirect_valid;
                    w_state_next = S_REQ;
                end else if (redirect_valid) begin
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                // The stale response retires the outstanding request; a redirect
                // arriving now only moves pc_q, the state logic is unaffected.
                if (imem_rsp_valid) begin
                    w_state_next = S_REQ;
                end
            end
            default: w_state_next = S_REQ;
        endcase
    end

    assign w_accept       = w_req_valid & imem_req_ready;
    assign imem_req_valid = w_req_valid;
    assign imem_addr      = r_pc;

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (w_accept) begin
            r_pc     <= r_pc + 32'd4;
            r_req_pc <= r_pc;
        end
    end

    // ------------------------------------------------------------------
    // Output buffer: pop shifts toward the head, push lands behind the
    // surviving entries, redirect empties it.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_buf_instr_next[i] = r_buf_instr[i];
            w_buf_pc_next[i]    = r_buf_pc[i];
        end
        w_count_pop = r_count - {1'b0, en_fd};
        if (en_fd) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_buf_instr_next[i] = r_buf_instr[i + 1];
                w_buf_pc_next[i]    = r_buf_pc[i + 1];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (w_count_pop == 2'(i))) begin
                w_buf_instr_next[i] = imem_rdata;
                w_buf_pc_next[i]    = r_req_pc;
            end
        end
        w_count_next = w_count_pop + {1'b0, w_push};
        if (redirect_valid) begin
            w_count_next = 2'd0;
        end
    end

    // NOTE: the buffer storage has no reset; only the occupancy count does,
    // and slots beyond the count are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_buf_instr[i] <= w_buf_instr_next[i];
            r_buf_pc[i]    <= w_buf_pc_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

    // Registered copy of the next head; holds its value while the buffer is
    // empty so decode always sees stable RD/PCF.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd       <= '0;
            r_pcf      <= '0;
            r_pc_plus4 <= '0;
        end else if (w_count_next != 2'd0) begin
            r_rd       <= w_buf_instr_next[0];
            r_pcf      <= w_buf_pc_next[0];
            r_pc_plus4 <= w_buf_pc_next[0] + 32'd4;
        end
    end

    assign RD        = r_rd;
    assign PCF       = r_pcf;
    assign PC_plus4F = r_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory
// answers each accepted request after a programmable latency with a word
// derived from its address. Expected fetch/decode entries are queued as
// stimulus is driven and compared whenever en_fd consumes an entry.
// Inputs are driven 2 time units after the rising edge; outputs are sampled
// on the falling edge or 1 unit after driving.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef FETCH_OUTBUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic [31:0] RD;
    logic [31:0] PCF;
    logic [31:0] PC_plus4F;
    logic        en_fd;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .RD             (RD),
        .PCF            (PCF),
        .PC_plus4F      (PC_plus4F),
        .en_fd          (en_fd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pop    = 0;
    int          n_acc    = 0;
    int          lat      = 1;
    bit          pend     = 1'b0;
    int          cnt      = 0;
    logic [31:0] paddr    = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = start + 32'(i * 4);
            sb.push_back('{pc: pc, instr: instr_of(pc), pc4: pc + 32'd4});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pops(input string tag, input int target);
        int b;
        b = 0;
        while (n_pop < target && b < 200) begin
            tick();
            b++;
        end
        check({tag, "_pops"}, 32'(n_pop), 32'(target));
    endtask

    task automatic wait_outstanding(input string tag);
        int b;
        b = 0;
        while (!(pend && cnt >= 2) && b < 50) begin
            tick();
            b++;
        end
        check({tag, "_outstanding"}, 32'(pend), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_RD"},        RD,                 32'd0);
        check({tag, "_PCF"},       PCF,                32'd0);
        check({tag, "_PC_plus4F"}, PC_plus4F,          32'd0);
        check({tag, "_en_fd"},     32'(en_fd),         32'd0);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    endtask

    // Instruction memory: accept sampled mid-cycle, response driven after the
    // edge once the latency counter expires.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rdata     = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
                n_acc++;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rdata     = instr_of(paddr);
                    pend           = 1'b0;
                end
            end
        end
    end

    // Scoreboard consumer: every en_fd pulse must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (en_fd === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_en_fd", 32'(en_fd), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("PCF",       PCF,       e.pc);
                    check("RD",        RD,        e.instr);
                    check("PC_plus4F", PC_plus4F, e.pc4);
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        rst            = 1'b1;
        stallF         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;

        // Reset state and first request in the first cycle after release.
        tick();
        tick();
        #1;
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;
        push_stream(RST_PC, 8);
        #1;
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr",  imem_addr,            RST_PC);
        wait_pops("run", 3);

        // Stall: no consumption, at most DEPTH words fetched ahead.
        stallF = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("stall_en_fd", 32'(en_fd), 32'd0);
            tick();
        end
        check("stall_PCF",   PCF,                RST_PC + 32'd12);
        check("stall_RD",    RD,                 instr_of(RST_PC + 32'd12));
        check("fetch_ahead", 32'(n_acc - n_pop), 32'(DEPTH));
        stallF = 1'b0;
        wait_pops("resume", 6);

        // Redirect with a request outstanding: stale word dropped.
        lat = 3;
        wait_outstanding("redirect");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        sb.delete();
        push_stream(32'h0000_0200, 12);
        #1;
        check("redir_req_valid", 32'(imem_req_valid), 32'd0);
        check("redir_en_fd",     32'(en_fd),          32'd0);
        tick();
        redirect_valid = 1'b0;
        lat            = 1;
        wait_pops("redirect", n_pop + 3);

        // Memory not ready: request held stable, one WAIT per acceptance.
        imem_req_ready = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("hold_req_valid", 32'(imem_req_valid), 32'd1);
            check("hold_req_addr",  imem_addr,            sb[0].pc);
            tick();
        end
        acc0           = n_acc;
        imem_req_ready = 1'b1;
        tick();
        check("one_accept", 32'(n_acc - acc0), 32'd1);
        #1;
        check("wait_no_req", 32'(imem_req_valid), 32'd0);
        wait_pops("ready", n_pop + 2);

        // Address wrap at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        sb.delete();
        push_stream(32'hFFFF_FFF8, 8);
        tick();
        redirect_valid = 1'b0;
        wait_pops("wrap", n_pop + 4);

        // Reset during WAIT; the late response must be ignored.
        lat = 3;
        wait_outstanding("midreset");
        rst = 1'b1;
        sb.delete();
        tick();
        #1;
        check_reset_outputs("midreset");
        tick();
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd1);
        check("rst_req_addr",  imem_addr,            RST_PC);
        tick();
        tick();
        lat            = 1;
        imem_req_ready = 1'b1;
        push_stream(RST_PC, 8);
        wait_pops("after_reset", n_pop + 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: owns the fetch PC, issues word requests to instruction memory over a valid/ready handshake and presents fetched instructions as RD/PCF/PC_plus4F with an enable strobe to the fetch/decode pipeline register. It honours the hazard unit's fetch stall, takes PC redirects from execute, discards stale in-flight responses and buffers returned words while decode is stalled.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- stallF  input  1  hazard unit stall; 1 = decode must not capture this cycle
- redirect_valid  input  1  single-cycle PC redirect (branch/jump taken in execute)
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0 internally
- imem_req_valid  output  1  request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  32  request word address
- imem_rsp_valid  input  1  response data valid (at least 1 cycle after acceptance)
- imem_rdata  input  32  response instruction word
- RD  output  32  instruction presented to fetch/decode register
- PCF  output  32  PC of RD
- PC_plus4F  output  32  PCF + 4 (mod 2^32)
- en_fd  output  1  enable of the fetch/decode register; 1 = entry consumed this cycle

## Operation
- State: pc_q (next address to request), req_pc_q (address of outstanding request), FSM {REQ, WAIT, DROP}, output buffer of DEPTH entries (DEPTH = 1, or 2 with FETCH_OUTBUF_EN), each {instr, pc}.
- At most one outstanding memory request; responses return in order.
- Credit: free = DEPTH − occupancy + (en_fd ? 1 : 0). In REQ, imem_req_valid = (free ≥ 1) & ~redirect_valid; imem_addr = pc_q.
- REQ: on imem_req_valid & imem_req_ready → req_pc_q <= pc_q, pc_q <= pc_q + 4 (wraps 32'hFFFF_FFFC → 0), go WAIT.
- WAIT: on imem_rsp_valid → push {imem_rdata, req_pc_q} into buffer, go REQ. Credit rule guarantees space.
- DROP: on imem_rsp_valid → discard response, go REQ.
- Response while in REQ (none outstanding, e.g. after reset) is ignored.
- Output: RD/PCF = head entry, PC_plus4F = head pc + 4; when buffer empty, outputs hold last values. en_fd = nonempty & ~stallF & ~redirect_valid; en_fd pops head.
- Redirect (priority over everything except rst): pc_q <= {redirect_pc[31:2], 2'b00}; buffer flushed; if in WAIT, or no request is accepted this cycle, → DROP if a request is outstanding, else REQ. Redirect in DROP stays DROP with updated pc_q. imem_req_valid forced 0 during the redirect cycle.
- Simultaneous push and pop in same cycle: both take effect; occupancy unchanged.
- Reset: pc_q = RESET_PC, FSM = REQ, buffer empty, RD = PCF = PC_plus4F = 0, en_fd = 0, imem_req_valid = 0 while rst = 1. Reset mid-transaction abandons the outstanding request; its late response is ignored.

## Timing
- imem_req_valid, imem_addr, en_fd are combinational from registered state and stallF/redirect_valid; RD/PCF/PC_plus4F come from registers only.
- Response accepted at edge N appears on RD/PCF at cycle N+1; en_fd can assert in cycle N+1.
- Request may be issued in the same cycle an entry pops (credit includes en_fd).
- First request issued in the first cycle after rst deasserts.
- Redirect at edge N: first request to target issued cycle N+1 if none outstanding; otherwise cycle after the stale response arrives.

## Configuration
- FETCH_OUTBUF_EN defined: DEPTH = 2; fetch continues one word ahead while stallF = 1, and a response arriving during a stall does not block the next request.
- Not defined: DEPTH = 1; no new request while the single entry is occupied and not being consumed.

## Test plan
- Reset, RESET_PC=32'h100, memory ready, 1-cycle latency, stallF=0 -> en_fd pulses with PCF = 0x100, 0x104, 0x108; PC_plus4F = PCF+4; RD matches memory.
- stallF held 3 cycles with entry valid -> en_fd=0, RD/PCF stable; no more than DEPTH words fetched ahead; stream resumes without loss or duplication.
- redirect_valid to 32'h200 while request to 0x10C outstanding -> 0x10C response discarded, buffer flushed, next en_fd shows PCF = 0x200.
- imem_req_ready low 4 cycles -> imem_req_valid and imem_addr held stable until accepted; exactly one WAIT per accepted request.
- pc at 32'hFFFF_FFFC -> next request address 0, PC_plus4F = 0.
- rst asserted while WAIT, late imem_rsp_valid after release -> response ignored, first en_fd shows PCF = RESET_PC.
